// File: rtl/alu_control_unit_if.sv
// ---------------------------------------------------------------------------
// alu_control_unit_if
// Bundles the three buses the control unit drives or observes:
//   - instruction fetch handshake : imem_req / imem_addr / imem_ack / imem_rdata
//   - data memory handshake       : dmem_rd_req / dmem_wr_req / dmem_addr /
//                                   dmem_wdata / dmem_ack / dmem_rdata
//   - ALU control bundle          : alu_u / alu_op1 / alu_op0 / alu_zx / alu_sw,
//                                   alu_x / alu_y operands, alu_result return
// master : the control unit (drives requests, ALU controls and operands)
// slave  : memories plus the combinational ALU (drive acks, read data, result)
// ---------------------------------------------------------------------------
interface alu_control_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  logic        dmem_rd_req;
  logic        dmem_wr_req;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;

  logic        alu_u;
  logic        alu_op1;
  logic        alu_op0;
  logic        alu_zx;
  logic        alu_sw;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_result;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_rd_req, dmem_wr_req, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata,
    output alu_u, alu_op1, alu_op0, alu_zx, alu_sw, alu_x, alu_y,
    input  alu_result
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_rd_req, dmem_wr_req, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata,
    input  alu_u, alu_op1, alu_op0, alu_zx, alu_sw, alu_x, alu_y,
    output alu_result
  );
endinterface

// File: rtl/alu_control_unit.sv
// ---------------------------------------------------------------------------
// alu_control_unit
// Multi-cycle control unit: fetches 16-bit instructions, loads constants into
// A, or drives the combinational ALU (control bits + X/Y operands), captures
// its result into A / D / *A, evaluates the jump condition and advances pc.
//
// Parameters:
//   RESET_PC   pc value loaded on reset
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        alu_control_unit_if.master (imem, dmem and ALU buses)
//   pc, a_reg, d_reg   architectural state, for debug
//   halted     halt flag
// Optional feature:
//   CU_HALT_DETECT_EN  when defined, an unconditional jump to itself
//                      (lt=eq=gt=1 with A == pc) parks the unit in HALT
//                      until reset; when undefined, halted is tied low.
// ---------------------------------------------------------------------------
module alu_control_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_control_unit_if.master  bus,
  output logic [15:0]         pc,
  output logic [15:0]         a_reg,
  output logic [15:0]         d_reg,
  output logic                halted
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MEM_RD,
    EXEC,
    MEM_WR
`ifdef CU_HALT_DETECT_EN
    ,
    HALT
`endif
  } state_t;

  state_t      state_reg;
  logic [15:0] ir_reg;
  logic [15:0] m_reg;

  logic        imem_req_reg;
  logic        dmem_rd_req_reg;
  logic        dmem_wr_req_reg;
  logic [15:0] dmem_addr_reg;
  logic [15:0] dmem_wdata_reg;

  logic        in_exec;
  logic [15:0] result;
  logic        r_neg;
  logic        r_zero;
  logic        r_pos;
  logic        jump_taken;
  logic [15:0] pc_inc;

  assign in_exec = (state_reg == EXEC);
  assign result  = bus.alu_result;
  assign r_neg   = result[15];
  assign r_zero  = (result == 16'h0000);
  assign r_pos   = !r_neg && !r_zero;
  assign jump_taken = (ir_reg[2] && r_neg) || (ir_reg[1] && r_zero) ||
                      (ir_reg[0] && r_pos);
  assign pc_inc  = pc + 16'd1;

  // The ALU bundle is a gated view of registered state (state, ir, A, D, M),
  // so it only moves on clock edges and is forced to zero outside EXEC.
  assign bus.alu_u   = in_exec & ir_reg[10];
  assign bus.alu_op1 = in_exec & ir_reg[9];
  assign bus.alu_op0 = in_exec & ir_reg[8];
  assign bus.alu_zx  = in_exec & ir_reg[7];
  assign bus.alu_sw  = in_exec & ir_reg[6];
  assign bus.alu_x   = in_exec ? d_reg : 16'h0000;
  assign bus.alu_y   = in_exec ? (ir_reg[12] ? m_reg : a_reg) : 16'h0000;

  assign bus.imem_req    = imem_req_reg;
  assign bus.imem_addr   = pc;
  assign bus.dmem_rd_req = dmem_rd_req_reg;
  assign bus.dmem_wr_req = dmem_wr_req_reg;
  assign bus.dmem_addr   = dmem_addr_reg;
  assign bus.dmem_wdata  = dmem_wdata_reg;

`ifdef CU_HALT_DETECT_EN
  logic halted_reg;
  logic halt_hit;
  assign halt_hit = (ir_reg[2:0] == 3'b111) && (a_reg == pc);
  assign halted   = halted_reg;
`else
  assign halted   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= FETCH;
      pc              <= RESET_PC;
      a_reg           <= 16'h0000;
      d_reg           <= 16'h0000;
      ir_reg          <= 16'h0000;
      m_reg           <= 16'h0000;
      imem_req_reg    <= 1'b0;
      dmem_rd_req_reg <= 1'b0;
      dmem_wr_req_reg <= 1'b0;
      dmem_addr_reg   <= 16'h0000;
      dmem_wdata_reg  <= 16'h0000;
`ifdef CU_HALT_DETECT_EN
      halted_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        FETCH: begin
          // The first FETCH after reset raises the request; an ack that is
          // still pending from before reset sees req low and is ignored.
          if (imem_req_reg && bus.imem_ack) begin
            ir_reg       <= bus.imem_rdata;
            imem_req_reg <= 1'b0;
            state_reg    <= DECODE;
          end else begin
            imem_req_reg <= 1'b1;
          end
        end

        DECODE: begin
          if (!ir_reg[15]) begin
            a_reg        <= {1'b0, ir_reg[14:0]};
            pc           <= pc_inc;
            imem_req_reg <= 1'b1;
            state_reg    <= FETCH;
          end else if (ir_reg[12]) begin
            dmem_rd_req_reg <= 1'b1;
            dmem_addr_reg   <= a_reg;
            state_reg       <= MEM_RD;
          end else begin
            state_reg <= EXEC;
          end
        end

        MEM_RD: begin
          if (bus.dmem_ack) begin
            m_reg           <= bus.dmem_rdata;
            dmem_rd_req_reg <= 1'b0;
            dmem_addr_reg   <= 16'h0000;
            state_reg       <= EXEC;
          end
        end

        EXEC: begin
          // Every source below (a_reg, pc) is the pre-EXEC value.
          if (ir_reg[4]) d_reg <= result;
          if (ir_reg[5]) a_reg <= result;
          pc <= jump_taken ? a_reg : pc_inc;
`ifdef CU_HALT_DETECT_EN
          // lt=eq=gt=1 always jumps, so pc already stays put when A == pc.
          if (halt_hit) begin
            halted_reg <= 1'b1;
            state_reg  <= HALT;
          end else
`endif
          if (ir_reg[3]) begin
            dmem_wr_req_reg <= 1'b1;
            dmem_addr_reg   <= a_reg;
            dmem_wdata_reg  <= result;
            state_reg       <= MEM_WR;
          end else begin
            imem_req_reg <= 1'b1;
            state_reg    <= FETCH;
          end
        end

        MEM_WR: begin
          if (bus.dmem_ack) begin
            dmem_wr_req_reg <= 1'b0;
            dmem_addr_reg   <= 16'h0000;
            dmem_wdata_reg  <= 16'h0000;
            imem_req_reg    <= 1'b1;
            state_reg       <= FETCH;
          end
        end

`ifdef CU_HALT_DETECT_EN
        HALT: begin
          state_reg <= HALT;
        end
`endif

        default: begin
          imem_req_reg    <= 1'b0;
          dmem_rd_req_reg <= 1'b0;
          dmem_wr_req_reg <= 1'b0;
          state_reg       <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_unit.sv
module tb_alu_control_unit;
  localparam logic [15:0] RESET_PC_TB = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic        halted;

  always #5 clk = ~clk;

  alu_control_unit_if bus();

  alu_control_unit #(.RESET_PC(RESET_PC_TB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .pc     (pc),
    .a_reg  (a_reg),
    .d_reg  (d_reg),
    .halted (halted)
  );

  int cmp_count  = 0;
  int fail_count = 0;

  // Architectural model: expected pc / A / D after the last instruction.
  logic [15:0] m_pc;
  logic [15:0] m_a;
  logic [15:0] m_d;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] a;
    logic [15:0] d;
  } arch_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  arch_t arch_q[$];
  wr_t   wr_q[$];

  typedef struct {
    logic [15:0] instr;
    logic [15:0] result;
    int          fw;
    logic [15:0] pc;
    logic [15:0] a;
    logic [15:0] d;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return bus.imem_req;
      1:       return bus.dmem_rd_req;
      default: return bus.dmem_wr_req;
    endcase
  endfunction

  // Bounded wait (in negedges) for a request to be high.
  task automatic wait_for(input int which, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (sig_of(which) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check($sformatf("timeout_req%0d", which), {15'b0, sig_of(which)}, 16'h0001);
  endtask

  // Runs one instruction through fetch / decode / (mem read) / exec / (mem write)
  // and, unless a halt is expected, checks the architectural state at the next fetch.
  task automatic exec_instr(input logic [15:0] instr, input logic [15:0] res,
                            input int fw, input logic [15:0] rd_data,
                            input int rd_waits, input int wr_waits,
                            input logic [15:0] exp_pc, input logic [15:0] exp_a,
                            input logic [15:0] exp_d, input bit expect_halt);
    bit          ok;
    logic [15:0] y_exp;
    arch_t       ae;
    wr_t         we;
    bus.alu_result = res;
    wait_for(0, 50, ok);
    check("imem_addr", bus.imem_addr, m_pc);
    check("one_req_fetch", {14'b0, bus.dmem_rd_req, bus.dmem_wr_req}, 16'h0000);
    for (int i = 0; i < fw; i++) begin
      @(negedge clk);
      check("imem_req_held", {15'b0, bus.imem_req}, 16'h0001);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = instr;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'hDEAD;
    check("imem_req_drop", {15'b0, bus.imem_req}, 16'h0000);
    check("alu_ctl_idle", {11'b0, bus.alu_u, bus.alu_op1, bus.alu_op0, bus.alu_zx, bus.alu_sw}, 16'h0000);
    if (!expect_halt) arch_q.push_back('{exp_pc, exp_a, exp_d});
    if (instr[15]) begin
      if (instr[12]) begin
        wait_for(1, 50, ok);
        check("rd_addr", bus.dmem_addr, m_a);
        check("one_req_rd", {15'b0, bus.imem_req}, 16'h0000);
        repeat (rd_waits) @(negedge clk);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rd_data;
        @(negedge clk);
        bus.dmem_ack   = 1'b0;
        y_exp = rd_data;
      end else begin
        @(negedge clk);
        y_exp = m_a;
      end
      check("alu_ctl", {11'b0, bus.alu_u, bus.alu_op1, bus.alu_op0, bus.alu_zx, bus.alu_sw},
            {11'b0, instr[10:6]});
      check("alu_x", bus.alu_x, m_d);
      check("alu_y", bus.alu_y, y_exp);
      if (instr[3] && !expect_halt) begin
        wr_q.push_back('{m_a, res});
        wait_for(2, 50, ok);
        we = wr_q.pop_front();
        check("wr_addr", bus.dmem_addr, we.addr);
        check("wr_data", bus.dmem_wdata, we.data);
        repeat (wr_waits) @(negedge clk);
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
      end
    end
    m_pc = exp_pc;
    m_a  = exp_a;
    m_d  = exp_d;
    if (!expect_halt) begin
      wait_for(0, 50, ok);
      ae = arch_q.pop_front();
      check("pc", pc, ae.pc);
      check("a_reg", a_reg, ae.a);
      check("d_reg", d_reg, ae.d);
    end
    $display("instr %h result %h -> pc=%h a=%h d=%h halted=%0b", instr, res, pc, a_reg, d_reg, halted);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    vecs[0]  = '{16'h0005, 16'h0000, 2, 16'h0001, 16'h0005, 16'h0000};
    vecs[1]  = '{16'h8410, 16'h0003, 0, 16'h0002, 16'h0005, 16'h0003};
    vecs[2]  = '{16'h8410, 16'h0008, 1, 16'h0003, 16'h0005, 16'h0008};
    vecs[3]  = '{16'h83F0, 16'h1234, 0, 16'h0004, 16'h1234, 16'h1234};
    vecs[4]  = '{16'h0020, 16'h0000, 3, 16'h0005, 16'h0020, 16'h1234};
    vecs[5]  = '{16'h8004, 16'h8000, 0, 16'h0020, 16'h0020, 16'h1234};
    vecs[6]  = '{16'h8004, 16'h0000, 1, 16'h0021, 16'h0020, 16'h1234};
    vecs[7]  = '{16'h8002, 16'h0000, 0, 16'h0020, 16'h0020, 16'h1234};
    vecs[8]  = '{16'h8001, 16'hFFFF, 2, 16'h0021, 16'h0020, 16'h1234};
    vecs[9]  = '{16'h8001, 16'h0001, 0, 16'h0020, 16'h0020, 16'h1234};
    vecs[10] = '{16'h7FFF, 16'h0000, 0, 16'h0021, 16'h7FFF, 16'h1234};
    vecs[11] = '{16'h84D0, 16'h00AA, 1, 16'h0022, 16'h7FFF, 16'h00AA};
    vecs[12] = '{16'h8002, 16'h0005, 0, 16'h0023, 16'h7FFF, 16'h00AA};

    rst_n          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 16'h0000;
    bus.alu_result = 16'h0000;
    m_pc = RESET_PC_TB;
    m_a  = 16'h0000;
    m_d  = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_reqs", {13'b0, bus.imem_req, bus.dmem_rd_req, bus.dmem_wr_req}, 16'h0000);
    check("rst_pc", pc, RESET_PC_TB);
    check("rst_a", a_reg, 16'h0000);
    check("rst_d", d_reg, 16'h0000);
    check("rst_halted", {15'b0, halted}, 16'h0000);
    check("rst_dmem_addr", bus.dmem_addr, 16'h0000);
    rst_n = 1'b1;

    // Table-driven constants, ALU ops and jumps
    for (int i = 0; i < 13; i++) begin
      exec_instr(vecs[i].instr, vecs[i].result, vecs[i].fw, 16'h0000, 0, 0,
                 vecs[i].pc, vecs[i].a, vecs[i].d, 1'b0);
    end

    // Memory read of M, write to *A with a late ack; A updated with the old A as address
    exec_instr(16'h0010, 16'h0000, 0, 16'h0000, 0, 0, 16'h0024, 16'h0010, 16'h00AA, 1'b0);
    exec_instr(16'h9408, 16'h0042, 0, 16'h0007, 0, 1, 16'h0025, 16'h0010, 16'h00AA, 1'b0);
    exec_instr(16'h9028, 16'h0055, 1, 16'h1234, 2, 0, 16'h0026, 16'h0055, 16'h00AA, 1'b0);

    // pc wrap-around from 16'hFFFF
    exec_instr(16'h8020, 16'hFFFF, 0, 16'h0000, 0, 0, 16'h0027, 16'hFFFF, 16'h00AA, 1'b0);
    exec_instr(16'h8007, 16'h0000, 0, 16'h0000, 0, 0, 16'hFFFF, 16'hFFFF, 16'h00AA, 1'b0);
    exec_instr(16'h0001, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0001, 16'h00AA, 1'b0);

    // Reset while dmem_wr_req is high
    exec_instr(16'h0030, 16'h0000, 0, 16'h0000, 0, 0, 16'h0001, 16'h0030, 16'h00AA, 1'b0);
    bus.alu_result = 16'h0099;
    wait_for(0, 50, ok);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h8008;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    @(negedge clk);
    wait_for(2, 50, ok);
    check("wr_addr_pre_rst", bus.dmem_addr, 16'h0030);
    check("wr_data_pre_rst", bus.dmem_wdata, 16'h0099);
    bus.dmem_ack = 1'b1;
    rst_n        = 1'b0;
    #1;
    check("rst_wr_req_drop", {15'b0, bus.dmem_wr_req}, 16'h0000);
    check("rst_wr_addr", bus.dmem_addr, 16'h0000);
    check("rst_mid_pc", pc, RESET_PC_TB);
    check("rst_mid_a", a_reg, 16'h0000);
    check("rst_mid_d", d_reg, 16'h0000);
    $display("reset during write: wr_req=%0b pc=%h", bus.dmem_wr_req, pc);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("stale_ack_no_wr", {15'b0, bus.dmem_wr_req}, 16'h0000);
    bus.dmem_ack = 1'b0;
    m_pc = RESET_PC_TB;
    m_a  = 16'h0000;
    m_d  = 16'h0000;

    // Unconditional jump to itself (A == pc == 0)
`ifdef CU_HALT_DETECT_EN
    exec_instr(16'h8007, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    check("halted", {15'b0, halted}, 16'h0001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_no_req", {13'b0, bus.imem_req, bus.dmem_rd_req, bus.dmem_wr_req}, 16'h0000);
    end
    check("halt_pc", pc, 16'h0000);
`else
    exec_instr(16'h8007, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    check("loop_imem_addr", bus.imem_addr, 16'h0000);
    check("loop_req", {15'b0, bus.imem_req}, 16'h0001);
    check("loop_halted", {15'b0, halted}, 16'h0000);
`endif

    check("arch_q_empty", 16'(arch_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
